// File: rtl/serial_addsub_if.sv
// Request/result bundle for the digit-serial adder/subtractor.
// The master issues operands with start; the slave returns the result and status flags.
interface serial_addsub_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, a, b, sub, cin,
        input  busy, done, s, cout, ovf, zero
    );

    modport slave (
        input  start, a, b, sub, cin,
        output busy, done, s, cout, ovf, zero
    );
endinterface

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock through a single carry register.
// S, COUT, OVF and ZERO are registered and change only on completion or reset.
module serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_addsub_if.slave bus
);

    localparam int N_DIGITS = WIDTH / DIGIT;
    localparam int CNT_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_DIGITS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               carry_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   bop_r;
    logic [WIDTH-1:0]   a_nxt_s;
    logic [WIDTH-1:0]   bop_nxt_s;
    logic [DIGIT:0]     dsum_s;
    logic               msb_cin_s;
    logic               accept_s;
    logic               step_s;
    logic               finish_s;

    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   s_r;
    logic               cout_r;
    logic               ovf_r;
    logic               zero_r;

    // One digit of A + Bop + carry; the top bit of the widened sum is the digit carry-out.
    assign dsum_s = {1'b0, a_r[DIGIT-1:0]} + {1'b0, bop_r[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_r};

    // Carry into the digit's top bit recovered from its sum; meaningful for OVF on the last digit.
    assign msb_cin_s = a_r[DIGIT-1] ^ bop_r[DIGIT-1] ^ dsum_s[DIGIT-1];

    // Sum digits enter the top of bop_r as its operand digits leave the bottom,
    // so after the last step bop_r holds the complete result.
    if (DIGIT == WIDTH) begin : g_full
        assign a_nxt_s   = a_r;
        assign bop_nxt_s = dsum_s[DIGIT-1:0];
    end else begin : g_part
        assign a_nxt_s   = {{DIGIT{1'b0}}, a_r[WIDTH-1:DIGIT]};
        assign bop_nxt_s = {dsum_s[DIGIT-1:0], bop_r[WIDTH-1:DIGIT]};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        step_s      = 1'b0;
        finish_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    accept_s    = 1'b1;
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (cnt_r == LAST_CNT) begin
                    finish_s    = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Operand latch on accept, then one digit per clock through the shared carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            bop_r   <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
        end else if (accept_s) begin
            a_r     <= bus.a;
            bop_r   <= bus.sub ? ~bus.b : bus.b;
            carry_r <= bus.cin;
            cnt_r   <= '0;
        end else if (step_s) begin
            a_r     <= a_nxt_s;
            bop_r   <= bop_nxt_s;
            carry_r <= dsum_s[DIGIT];
            cnt_r   <= cnt_r + 1'b1;
        end
    end

    // Registered status and result; S and flags load only on the finishing step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            s_r    <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s == RUN);
            done_r <= finish_s;
            if (finish_s) begin
                s_r    <= bop_nxt_s;
                cout_r <= dsum_s[DIGIT];
                ovf_r  <= msb_cin_s ^ dsum_s[DIGIT];
                zero_r <= (bop_nxt_s == '0);
            end
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.s    = s_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;
    assign bus.zero = zero_r;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed cases plus random sweeps over four
// WIDTH/DIGIT configurations, compared against a plain-arithmetic reference model.
module tb_serial_addsub;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Config 0: 16/4, 1: 16/1, 2: 16/16, 3: 8/2
    int w_c[4] = '{16, 16, 16, 8};
    int n_c[4] = '{4, 16, 1, 4};

    logic        start_m[4];
    logic [15:0] a_m[4];
    logic [15:0] b_m[4];
    logic        sub_m[4];
    logic        cin_m[4];
    logic        busy_m[4];
    logic        done_m[4];
    logic [15:0] s_m[4];
    logic        cout_m[4];
    logic        ovf_m[4];
    logic        zero_m[4];

    serial_addsub_if #(.WIDTH(16)) if0 ();
    serial_addsub_if #(.WIDTH(16)) if1 ();
    serial_addsub_if #(.WIDTH(16)) if2 ();
    serial_addsub_if #(.WIDTH(8))  if3 ();

    serial_addsub #(.WIDTH(16), .DIGIT(4))  dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    serial_addsub #(.WIDTH(16), .DIGIT(1))  dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    serial_addsub #(.WIDTH(16), .DIGIT(16)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    serial_addsub #(.WIDTH(8),  .DIGIT(2))  dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    assign if0.start = start_m[0];
    assign if0.a     = a_m[0];
    assign if0.b     = b_m[0];
    assign if0.sub   = sub_m[0];
    assign if0.cin   = cin_m[0];
    assign if1.start = start_m[1];
    assign if1.a     = a_m[1];
    assign if1.b     = b_m[1];
    assign if1.sub   = sub_m[1];
    assign if1.cin   = cin_m[1];
    assign if2.start = start_m[2];
    assign if2.a     = a_m[2];
    assign if2.b     = b_m[2];
    assign if2.sub   = sub_m[2];
    assign if2.cin   = cin_m[2];
    assign if3.start = start_m[3];
    assign if3.a     = a_m[3][7:0];
    assign if3.b     = b_m[3][7:0];
    assign if3.sub   = sub_m[3];
    assign if3.cin   = cin_m[3];

    assign busy_m[0] = if0.busy;
    assign done_m[0] = if0.done;
    assign s_m[0]    = if0.s;
    assign cout_m[0] = if0.cout;
    assign ovf_m[0]  = if0.ovf;
    assign zero_m[0] = if0.zero;
    assign busy_m[1] = if1.busy;
    assign done_m[1] = if1.done;
    assign s_m[1]    = if1.s;
    assign cout_m[1] = if1.cout;
    assign ovf_m[1]  = if1.ovf;
    assign zero_m[1] = if1.zero;
    assign busy_m[2] = if2.busy;
    assign done_m[2] = if2.done;
    assign s_m[2]    = if2.s;
    assign cout_m[2] = if2.cout;
    assign ovf_m[2]  = if2.ovf;
    assign zero_m[2] = if2.zero;
    assign busy_m[3] = if3.busy;
    assign done_m[3] = if3.done;
    assign s_m[3]    = {8'd0, if3.s};
    assign cout_m[3] = if3.cout;
    assign ovf_m[3]  = if3.ovf;
    assign zero_m[3] = if3.zero;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: modulo-2^w sum of A, effective B and CIN; overflow by the sign rule.
    function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                  input logic sub, input logic cin,
                                  output int s, output int c, output int o, output int z);
        int mask, aa, bb, full, msb;
        mask = (1 << w) - 1;
        aa   = int'(a) & mask;
        bb   = (sub ? ~int'(b) : int'(b)) & mask;
        full = aa + bb + int'(cin);
        s    = full & mask;
        c    = (full >> w) & 1;
        msb  = w - 1;
        o    = ((((aa >> msb) & 1) == ((bb >> msb) & 1)) && (((s >> msb) & 1) != ((aa >> msb) & 1))) ? 1 : 0;
        z    = (s == 0) ? 1 : 0;
    endfunction

    task automatic drive_ops(input int idx, input logic [15:0] a, input logic [15:0] b,
                             input logic sub, input logic cin);
        a_m[idx]   = a;
        b_m[idx]   = b;
        sub_m[idx] = sub;
        cin_m[idx] = cin;
    endtask

    task automatic scramble_ops(input int idx);
        drive_ops(idx, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    endtask

    // One complete operation; entered and left at posedge+1 with the DUT idle.
    task automatic run_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic cin);
        int es, ec, eo, ez, lat;
        bit seen;
        model(w_c[idx], a, b, sub, cin, es, ec, eo, ez);
        start_m[idx] = 1'b1;
        drive_ops(idx, a, b, sub, cin);
        @(posedge clk); #1;
        start_m[idx] = 1'b0;
        scramble_ops(idx);
        check_eq("busy_after_accept", 32'(busy_m[idx]), 32'd1);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (done_m[idx]) seen = 1'b1;
            else check_eq("busy_in_run", 32'(busy_m[idx]), 32'd1);
        end
        check_eq("latency", 32'(lat), 32'(n_c[idx]));
        check_eq("s", 32'(s_m[idx]), 32'(es));
        check_eq("cout", 32'(cout_m[idx]), 32'(ec));
        check_eq("ovf", 32'(ovf_m[idx]), 32'(eo));
        check_eq("zero", 32'(zero_m[idx]), 32'(ez));
        check_eq("busy_at_done", 32'(busy_m[idx]), 32'd0);
        @(posedge clk); #1;
        check_eq("done_pulse", 32'(done_m[idx]), 32'd0);
        check_eq("s_hold", 32'(s_m[idx]), 32'(es));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] ha[4];
        logic [15:0] hb[4];
        logic        hs[4];
        logic        hc[4];
        int es, ec, eo, ez, nd;

        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start_m[i] = 1'b0;
            drive_ops(i, 16'h0000, 16'h0000, 1'b0, 1'b0);
        end
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy_m[0]), 32'd0);
        check_eq("rst_done", 32'(done_m[0]), 32'd0);
        check_eq("rst_s", 32'(s_m[0]), 32'd0);
        check_eq("rst_flags", {29'd0, cout_m[0], ovf_m[0], zero_m[0]}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Overflow, subtract, borrow and wrap-to-zero cases
        run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        check_eq("tp1_s", 32'(s_m[0]), 32'h8000);
        check_eq("tp1_ovf", 32'(ovf_m[0]), 32'd1);
        run_op(0, 16'h000A, 16'h0005, 1'b1, 1'b1);
        check_eq("tp2_s", 32'(s_m[0]), 32'h0005);
        run_op(0, 16'h0003, 16'h0005, 1'b1, 1'b1);
        check_eq("tp2_borrow", {16'd0, s_m[0], 15'd0, cout_m[0]}, 32'hFFFE_0000);
        run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        check_eq("tp3_zero", 32'(zero_m[0]), 32'd1);
        run_op(0, 16'h8000, 16'h0001, 1'b1, 1'b1);
        check_eq("tp3_s", 32'(s_m[0]), 32'h7FFF);

        // START held high: accepts at edges 0, 5, 10; operands churn in between
        for (int i = 0; i < 4; i++) begin
            ha[i] = 16'($urandom);
            hb[i] = 16'($urandom);
            hs[i] = 1'($urandom);
            hc[i] = 1'($urandom);
        end
        start_m[0] = 1'b1;
        drive_ops(0, ha[0], hb[0], hs[0], hc[0]);
        for (int t = 0; t < 15; t++) begin
            @(posedge clk); #1;
            if (t % 5 == 4) begin
                model(16, ha[t / 5], hb[t / 5], hs[t / 5], hc[t / 5], es, ec, eo, ez);
                check_eq("hs_done", 32'(done_m[0]), 32'd1);
                check_eq("hs_s", 32'(s_m[0]), 32'(es));
                check_eq("hs_flags", {29'd0, cout_m[0], ovf_m[0], zero_m[0]},
                         32'((ec << 2) | (eo << 1) | ez));
                check_eq("hs_busy_done", 32'(busy_m[0]), 32'd0);
            end else begin
                check_eq("hs_no_done", 32'(done_m[0]), 32'd0);
                check_eq("hs_busy", 32'(busy_m[0]), 32'd1);
            end
            if (t == 14) begin
                start_m[0] = 1'b0;
            end else if ((t + 1) % 5 == 0) begin
                drive_ops(0, ha[(t + 1) / 5], hb[(t + 1) / 5], hs[(t + 1) / 5], hc[(t + 1) / 5]);
            end else begin
                scramble_ops(0);
            end
        end
        @(posedge clk); #1;

        // Asynchronous reset in the second RUN cycle abandons the operation
        run_op(0, 16'h1234, 16'h0F0F, 1'b0, 1'b1);
        start_m[0] = 1'b1;
        drive_ops(0, 16'h4321, 16'h1111, 1'b0, 1'b0);
        @(posedge clk); #1;
        start_m[0] = 1'b0;
        @(posedge clk); #4;
        rst_n = 1'b0;
        #1;
        check_eq("arst_busy", 32'(busy_m[0]), 32'd0);
        check_eq("arst_done", 32'(done_m[0]), 32'd0);
        check_eq("arst_s", 32'(s_m[0]), 32'd0);
        check_eq("arst_flags", {29'd0, cout_m[0], ovf_m[0], zero_m[0]}, 32'd0);
        @(posedge clk); #4;
        rst_n = 1'b1;
        nd = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done_m[0]) nd++;
        end
        check_eq("arst_no_done", 32'(nd), 32'd0);
        run_op(0, 16'hABCD, 16'h1234, 1'b1, 1'b1);

        // Random sweeps across all configurations
        for (int idx = 0; idx < 4; idx++) begin
            for (int k = 0; k < ((idx == 0) ? 200 : 1000); k++) begin
                run_op(idx, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised, digit-serial successor to the combinational ripple-carry adder/subtractor.
- Accepts WIDTH-bit operands with a START handshake and processes DIGIT bits per clock through one carry register.
- Presents a registered result with carry, signed-overflow and zero flags.
- Used where ALU area matters more than latency; the subtract convention matches the existing subtractor (S = A + ~B + CIN).

Parameters:
- WIDTH, 16, operand/result width in bits; must be ≥ 2.
- DIGIT, 4, bits processed per clock; must divide WIDTH exactly, 1 ≤ DIGIT ≤ WIDTH.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  request; sampled only while idle.
- A  in  WIDTH  operand A, latched on accept.
- B  in  WIDTH  operand B, latched on accept.
- SUB  in  1  0 = add, 1 = subtract (B inverted); latched on accept.
- CIN  in  1  initial carry, latched on accept (CIN=1 with SUB=1 gives A−B).
- BUSY  out  1  high while an operation is in flight.
- DONE  out  1  one-cycle pulse when S and flags update.
- S  out  WIDTH  result register.
- COUT  out  1  carry out of bit WIDTH−1.
- OVF  out  1  two's-complement overflow.
- ZERO  out  1  high when S == 0.

Behaviour:
- Reset (RST_N low, asynchronous, any time):
  - State goes to IDLE; digit counter, carry and operand registers clear.
  - BUSY=0, DONE=0, S=0, COUT=0, OVF=0, ZERO=0.
  - An operation in flight is abandoned; no DONE is produced for it.
- Let N = WIDTH/DIGIT.
- State IDLE:
  - START=1 at a rising edge is accepted.
  - On accept: latch A; latch Bop = SUB ? ~B : B; carry ← CIN; count ← 0; go to RUN; BUSY=1 from that edge.
- State RUN:
  - Each edge adds digit[count] of A, Bop and carry.
  - The DIGIT sum bits go into the internal result shift register; carry ← digit carry-out; count ← count+1.
  - On the edge that processes digit N−1:
    - Return to IDLE; BUSY=0; DONE=1 for exactly one cycle.
    - S ← full result.
    - COUT ← final carry.
    - OVF ← carry into MSB XOR carry out of MSB.
    - ZERO ← (result == 0).
- Latency: DONE and the new S are visible after the N-th edge following the accept edge.
  - WIDTH=16, DIGIT=4: 4 edges. DIGIT=WIDTH: 1 edge. DIGIT=1: WIDTH edges.
- S and the flags change only on completion or reset; they hold their values through IDLE and RUN otherwise.
- START while BUSY=1 is ignored, not queued, and does not disturb the operation or the latched operands.
- START high in the DONE cycle is accepted, because the state is IDLE. Back-to-back operations therefore have a throughput of one per N+1 cycles.
- Inputs A, B, SUB and CIN may change freely after the accept edge.
- Arithmetic is modulo 2^WIDTH.
  - COUT in subtract mode is the inverted borrow: 1 means A ≥ B when CIN=1.
  - OVF is evaluated on the effective operands A and Bop.
- A single state register with 2 states is used; the count is ceil(log2(N)) bits wide, at least 1 bit.

Test Plan (WIDTH=16, DIGIT=4 unless stated):
1. A=0x7FFF, B=0x0001, SUB=0, CIN=0, START pulse → DONE exactly 4 cycles after accept; S=0x8000, COUT=0, OVF=1, ZERO=0; BUSY high for 4 cycles.
2. A=0x000A, B=0x0005, SUB=1, CIN=1 → S=0x0005, COUT=1, OVF=0. Then A=0x0003, B=0x0005 → S=0xFFFE, COUT=0, OVF=0.
3. A=0xFFFF, B=0x0001, SUB=0, CIN=0 → S=0x0000, COUT=1, ZERO=1, OVF=0. Then A=0x8000, B=0x0001, SUB=1, CIN=1 → S=0x7FFF, OVF=1.
4. Handshake:
   - START held high continuously with operands changing every cycle during RUN → only the operands present at each accept edge are used.
   - A new operation is accepted in the DONE cycle.
   - DONE pulses once per operation, 5 cycles apart.
5. Reset: assert RST_N low asynchronously (mid-cycle) during the 2nd RUN cycle → all outputs 0 immediately; no DONE afterwards; the next START completes normally.
6. Parameter sweep with random operands against a golden model:
   - DIGIT=1: latency 16.
   - DIGIT=16: latency 1.
   - WIDTH=8, DIGIT=2: latency 4.
   - Check S, COUT, OVF, ZERO for 1000 random add/sub vectors per configuration.
